// File: rtl/pm_ctrl_pkg.sv
// Shared types and defaults for the PM control-path request steering blocks.
// Holds the demux FSM state encoding and the default synchronizer/timeout sizes.
// No logic lives here; it is imported by the demux top and its helpers.
package pm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_DROP = 2'd3
  } pm_demux_state_t;

  localparam int PM_SYNC_STAGES_DEF = 2;
  localparam int PM_TIMEOUT_DEF     = 255;

endpackage

// File: rtl/pm_ctrl_sync.sv
// N-flop single-bit synchronizer for acknowledges arriving from another domain.
// Latency: N cycles of clk from d to q.
// No flow control; the output simply follows the input N cycles late.
module pm_ctrl_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // Shift the asynchronous input through N flops; all clear to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/pm_ctrl_demux1v2_seq.sv
// Registered 1-to-2 four-phase request demux toward two power-domain controllers.
// Latency: dn_req 1 cycle after up_req accepted; up_ack 1 cycle after synchronized ack.
// Upstream is held in its handshake until the chosen channel acks or the timeout aborts.
module pm_ctrl_demux1v2_seq
  import pm_ctrl_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = PM_SYNC_STAGES_DEF,
  parameter int TIMEOUT     = PM_TIMEOUT_DEF,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_req,
  input  logic [W-1:0] up_data,
  input  logic         sel,
  output logic         up_ack,
  output logic [1:0]   dn_req,
  output logic [W-1:0] dn_data0,
  output logic [W-1:0] dn_data1,
  input  logic [1:0]   dn_ack,
  output logic         err,
  input  logic         err_clr,
  output logic         busy
);

  localparam logic             TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pm_demux_state_t state;
  pm_demux_state_t state_d;
  logic             sel_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ack_s;
  logic             ack_sel;
  logic             to_hit;
  logic             to_evt;
  logic             accept;
  logic             rearm;
  logic [1:0]       dn_req_d;
  logic             up_ack_d;

  for (genvar g = 0; g < 2; g++) begin : g_sync
    pm_ctrl_sync #(.N(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dn_ack[g]),
      .q     (ack_s[g])
    );
  end

  // Only the latched channel's ack is ever looked at.
  assign ack_sel = ack_s[sel_q];
  assign to_hit  = TO_EN && (cnt == TO_VAL);
  assign to_evt  = (state == ST_REQ) && !ack_sel && to_hit;
  // rearm blocks acceptance in the first IDLE cycle after a completed handshake.
  assign accept  = (state == ST_IDLE) && up_req && !rearm;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode for the four-phase sequence.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept)            state_d = ST_REQ;
      ST_REQ:  if (ack_sel || to_hit) state_d = ST_ACK;
      ST_ACK:  if (!up_req)           state_d = ST_DROP;
      ST_DROP: if (!ack_sel)          state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    dn_req_d = dn_req;
    up_ack_d = up_ack;
    case (state)
      ST_IDLE: begin
        if (accept) dn_req_d = sel ? 2'b10 : 2'b01;
      end
      ST_REQ: begin
        if (ack_sel) begin
          up_ack_d = 1'b1;
        end else if (to_hit) begin
          up_ack_d = 1'b1;
          dn_req_d = 2'b00;
        end
      end
      ST_ACK: begin
        if (!up_req) dn_req_d = 2'b00;
      end
      ST_DROP: begin
        if (!ack_sel) up_ack_d = 1'b0;
      end
      default: begin
        dn_req_d = 2'b00;
        up_ack_d = 1'b0;
      end
    endcase
  end

  // Output flops, sticky error and the post-handshake rearm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_req <= 2'b00;
      up_ack <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      rearm  <= 1'b0;
    end else begin
      dn_req <= dn_req_d;
      up_ack <= up_ack_d;
      busy   <= (state_d != ST_IDLE);
      rearm  <= (state == ST_DROP) && (state_d == ST_IDLE);
      if (to_evt) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // Latch destination and payload at acceptance; run the saturating REQ timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= 1'b0;
      cnt      <= '0;
      dn_data0 <= '0;
      dn_data1 <= '0;
    end else begin
      if (accept) begin
        sel_q <= sel;
        cnt   <= '0;
        if (sel) dn_data1 <= up_data;
        else     dn_data0 <= up_data;
      end else if ((state == ST_REQ) && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pm_ctrl_demux1v2_seq.sv
// Directed bench for the 1-to-2 PM request demux.
// Table of transactions plus hand sequences for reset, err clear and back-to-back.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pm_ctrl_demux1v2_seq;

  localparam int SS = 2;
  localparam int TO = 10;

  logic       clk;
  logic       rst_n;
  logic       up_req;
  logic [7:0] up_data;
  logic       sel;
  logic       up_ack;
  logic [1:0] dn_req;
  logic [7:0] dn_data0;
  logic [7:0] dn_data1;
  logic [1:0] dn_ack;
  logic       err;
  logic       err_clr;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    int         ack_dly;  // -1: channel never acks
    logic       spur;     // raise the other channel's ack during the handshake
    logic       toggle;   // change sel/up_data after acceptance
    int         lat;      // cycles from up_req to dn_req
    logic [1:0] exp_req;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;
    logic       exp_err;
  } vec_t;

  pm_ctrl_demux1v2_seq #(
    .W(8), .SYNC_STAGES(SS), .TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_req   (up_req),
    .up_data  (up_data),
    .sel      (sel),
    .up_ack   (up_ack),
    .dn_req   (dn_req),
    .dn_data0 (dn_data0),
    .dn_data1 (dn_data1),
    .dn_ack   (dn_ack),
    .err      (err),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t t, input bit tail);
    logic other;
    other   = ~t.sel;
    sel     = t.sel;
    up_data = t.data;
    up_req  = 1'b1;
    for (int i = 1; i < t.lat; i++) begin
      @(negedge clk);
      chk("req_gap", 32'(dn_req), 32'd0);
    end
    @(negedge clk);
    chk("req_rise", 32'(dn_req), 32'(t.exp_req));
    chk("data0_load", 32'(dn_data0), 32'(t.exp_d0));
    chk("data1_load", 32'(dn_data1), 32'(t.exp_d1));
    chk("busy_req", 32'(busy), 32'd1);
    chk("ack_in_req", 32'(up_ack), 32'd0);
    if (t.toggle) begin
      sel     = ~t.sel;
      up_data = ~t.data;
    end
    if (t.spur) dn_ack[other] = 1'b1;
    if (t.ack_dly >= 0) begin
      repeat (t.ack_dly) @(negedge clk);
      dn_ack[t.sel] = 1'b1;
      repeat (SS) @(negedge clk);
      chk("ack_early", 32'(up_ack), 32'd0);
      chk("req_hold", 32'(dn_req), 32'(t.exp_req));
      @(negedge clk);
      chk("ack_rise", 32'(up_ack), 32'd1);
      chk("req_in_ack", 32'(dn_req), 32'(t.exp_req));
    end else begin
      repeat (TO) @(negedge clk);
      chk("to_pre_ack", 32'(up_ack), 32'd0);
      chk("to_pre_err", 32'(err), 32'd0);
      chk("to_pre_req", 32'(dn_req), 32'(t.exp_req));
      @(negedge clk);
      chk("to_ack", 32'(up_ack), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      chk("to_req_drop", 32'(dn_req), 32'd0);
    end
    chk("err_state", 32'(err), 32'(t.exp_err));
    chk("data0_keep", 32'(dn_data0), 32'(t.exp_d0));
    chk("data1_keep", 32'(dn_data1), 32'(t.exp_d1));
    up_req = 1'b0;
    @(negedge clk);
    chk("req_fall", 32'(dn_req), 32'd0);
    chk("ack_hold", 32'(up_ack), 32'd1);
    if (t.ack_dly >= 0) begin
      dn_ack[t.sel] = 1'b0;
      repeat (SS) @(negedge clk);
      chk("ack_drop_wait", 32'(up_ack), 32'd1);
    end
    @(negedge clk);
    chk("ack_fall", 32'(up_ack), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    dn_ack = 2'b00;
    if (tail) @(negedge clk);
  endtask

  vec_t vecs[5];
  vec_t post_rst;
  vec_t b2b0;
  vec_t b2b1;

  initial begin
    //          sel   data   dly  spur  tgl  lat  req    d0     d1     err
    vecs[0] = '{1'b0, 8'hA5,  3, 1'b0, 1'b0, 1, 2'b01, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'h3C,  2, 1'b0, 1'b1, 1, 2'b10, 8'hA5, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 8'h5A,  1, 1'b1, 1'b0, 1, 2'b01, 8'h5A, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 8'hC3,  0, 1'b0, 1'b0, 1, 2'b10, 8'h5A, 8'hC3, 1'b0};
    vecs[4] = '{1'b0, 8'h0F, -1, 1'b0, 1'b0, 1, 2'b01, 8'h0F, 8'hC3, 1'b1};
    post_rst = '{1'b0, 8'h99, 3, 1'b0, 1'b0, 1, 2'b01, 8'h99, 8'h00, 1'b0};
    b2b0     = '{1'b0, 8'h11, 1, 1'b0, 1'b0, 1, 2'b01, 8'h11, 8'h00, 1'b0};
    b2b1     = '{1'b1, 8'h22, 1, 1'b0, 1'b0, 2, 2'b10, 8'h11, 8'h22, 1'b0};

    rst_n   = 1'b0;
    up_req  = 1'b0;
    up_data = 8'h00;
    sel     = 1'b0;
    dn_ack  = 2'b00;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_up_ack", 32'(up_ack), 32'd0);
    chk("rst_dn_req", 32'(dn_req), 32'd0);
    chk("rst_data0", 32'(dn_data0), 32'd0);
    chk("rst_data1", 32'(dn_data1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], 1'b1);

    // err is sticky until cleared
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    @(negedge clk);

    // reset asserted while in ACK
    sel     = 1'b1;
    up_data = 8'h77;
    up_req  = 1'b1;
    @(negedge clk);
    chk("rst_seq_req", 32'(dn_req), 32'd2);
    dn_ack[1] = 1'b1;
    repeat (SS + 1) @(negedge clk);
    chk("rst_seq_ack", 32'(up_ack), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ack", 32'(up_ack), 32'd0);
    chk("mid_rst_req", 32'(dn_req), 32'd0);
    chk("mid_rst_data1", 32'(dn_data1), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    up_req = 1'b0;
    dn_ack = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", 32'(up_ack), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_txn(post_rst, 1'b1);

    // back-to-back: second request raised as soon as up_ack is seen low
    run_txn(b2b0, 1'b0);
    run_txn(b2b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
